// File: rtl/mem_access_arbiter_pkg.sv
// Shared types for the memory access arbiter: bus widths, the UART address,
// the action token and the arbiter state encoding.
package mem_access_arbiter_pkg;

  typedef logic [15:0] mem_addr_t;
  typedef logic [15:0] mem_value_t;
  typedef logic [31:0] act_token_t;

  localparam mem_addr_t  UART_ADDR     = 16'hFF00;
  localparam mem_value_t TIMEOUT_VALUE = 16'hFFFF;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_WAIT = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWNER_IF   = 1'b0,
    OWNER_DATA = 1'b1
  } owner_e;

  // Tokens wrap freely; the controller only checks them for inequality.
  function automatic act_token_t next_token(input act_token_t tok);
    return tok + 32'd1;
  endfunction

endpackage

// File: rtl/mem_access_arbiter_if.sv
// Bundle of the fetch port, data port and controller port seen by the arbiter.
// The slave side is the arbiter; the master side is the pipeline plus controller.
interface mem_access_arbiter_if;
  import mem_access_arbiter_pkg::*;

  logic       if_req;
  mem_addr_t  if_addr;
  mem_value_t if_rdata;
  logic       if_ready;

  logic       d_rd;
  logic       d_wr;
  mem_addr_t  d_addr;
  mem_value_t d_wdata;
  mem_value_t d_rdata;
  logic       d_ready;

  logic       stall;

  logic       ctl_rd;
  logic       ctl_wr;
  mem_addr_t  ctl_addr;
  mem_value_t ctl_value;
  act_token_t ctl_act;
  logic       ctl_done;
  mem_value_t ctl_result;
  logic       err;

  modport slave (
    input  if_req, if_addr, d_rd, d_wr, d_addr, d_wdata, ctl_done, ctl_result,
    output if_rdata, if_ready, d_rdata, d_ready, stall,
           ctl_rd, ctl_wr, ctl_addr, ctl_value, ctl_act, err
  );

  modport master (
    output if_req, if_addr, d_rd, d_wr, d_addr, d_wdata, ctl_done, ctl_result,
    input  if_rdata, if_ready, d_rdata, d_ready, stall,
           ctl_rd, ctl_wr, ctl_addr, ctl_value, ctl_act, err
  );

endinterface

// File: rtl/mem_access_arbiter.sv
// Shares one controller request port between the fetch and data stages,
// data first, tagging each access with a fresh token and bounding its wait.
module mem_access_arbiter
  import mem_access_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_access_arbiter_if.slave  bus
);

  localparam int              CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_e       r_state;
  arb_state_e       w_state_next;
  owner_e           r_owner;
  logic             r_ctl_rd;
  logic             r_ctl_wr;
  mem_addr_t        r_ctl_addr;
  mem_value_t       r_ctl_value;
  act_token_t       r_ctl_act;
  mem_value_t       r_if_rdata;
  mem_value_t       r_d_rdata;
  logic             r_err;
  logic [CNT_W-1:0] r_cnt;

  logic       w_d_req;
  logic       w_grant;
  logic       w_timeout;
  logic       w_finish;
  mem_value_t w_resp_value;
  logic       w_if_ready;
  logic       w_d_ready;

  assign w_d_req      = bus.d_rd | bus.d_wr;
  assign w_grant      = (r_state == ARB_IDLE) && (w_d_req || bus.if_req);
  // Done wins over a timeout landing on the same edge.
  assign w_timeout    = (r_state == ARB_WAIT) && !bus.ctl_done && (r_cnt == CNT_LAST);
  assign w_finish     = (r_state == ARB_WAIT) && (bus.ctl_done || w_timeout);
  assign w_resp_value = bus.ctl_done ? bus.ctl_result : TIMEOUT_VALUE;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ARB_IDLE: if (w_grant)  w_state_next = ARB_WAIT;
      ARB_WAIT: if (w_finish) w_state_next = ARB_RESP;
      ARB_RESP: w_state_next = ARB_IDLE;
      default:  w_state_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner     <= OWNER_IF;
      r_ctl_rd    <= 1'b0;
      r_ctl_wr    <= 1'b0;
      r_ctl_addr  <= '0;
      r_ctl_value <= '0;
      r_ctl_act   <= '0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
      r_err       <= 1'b0;
      r_cnt       <= '0;
    end else if (w_grant) begin
      // A simultaneous read and write from the data stage is issued as a write.
      r_owner     <= w_d_req ? OWNER_DATA : OWNER_IF;
      r_ctl_wr    <= bus.d_wr;
      r_ctl_rd    <= ~bus.d_wr;
      r_ctl_addr  <= w_d_req ? bus.d_addr : bus.if_addr;
      r_ctl_value <= w_d_req ? bus.d_wdata : '0;
      r_ctl_act   <= next_token(r_ctl_act);
      r_cnt       <= '0;
    end else if (w_finish) begin
      r_ctl_rd <= 1'b0;
      r_ctl_wr <= 1'b0;
      if (r_owner == OWNER_IF) begin
        r_if_rdata <= w_resp_value;
      end else begin
        r_d_rdata <= w_resp_value;
      end
      if (!bus.ctl_done) begin
        r_err <= 1'b1;
      end
    end else if (r_state == ARB_WAIT) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign w_if_ready = (r_state == ARB_RESP) && (r_owner == OWNER_IF);
  assign w_d_ready  = (r_state == ARB_RESP) && (r_owner == OWNER_DATA);

  assign bus.if_ready  = w_if_ready;
  assign bus.d_ready   = w_d_ready;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.d_rdata   = r_d_rdata;
  assign bus.stall     = (bus.if_req & ~w_if_ready) | (w_d_req & ~w_d_ready);
  assign bus.ctl_rd    = r_ctl_rd;
  assign bus.ctl_wr    = r_ctl_wr;
  assign bus.ctl_addr  = r_ctl_addr;
  assign bus.ctl_value = r_ctl_value;
  assign bus.ctl_act   = r_ctl_act;
  assign bus.err       = r_err;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Random and directed traffic for the memory access arbiter, checked against a
// transaction-level model of priority, tokens, latency and timeout.
module tb_mem_access_arbiter;
  import mem_access_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mem_access_arbiter_if bus();
  mem_access_arbiter_if bus_to();

  mem_access_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  mem_access_arbiter #(.TIMEOUT(16)) dut_to (
    .clk (clk),
    .rst (rst),
    .bus (bus_to)
  );

  int         n_checks = 0;
  int         n_errors = 0;
  int         n_txn    = 0;
  act_token_t tok_model;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive_idle();
    bus.if_req     = 1'b0;
    bus.if_addr    = '0;
    bus.d_rd       = 1'b0;
    bus.d_wr       = 1'b0;
    bus.d_addr     = '0;
    bus.d_wdata    = '0;
    bus.ctl_done   = 1'b0;
    bus.ctl_result = '0;
    bus_to.if_req     = 1'b0;
    bus_to.if_addr    = '0;
    bus_to.d_rd       = 1'b0;
    bus_to.d_wr       = 1'b0;
    bus_to.d_addr     = '0;
    bus_to.d_wdata    = '0;
    bus_to.ctl_done   = 1'b0;
    bus_to.ctl_result = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    tok_model = '0;
  endtask

  // Acts as the controller for one access on the main port, starting from IDLE
  // with the stage requests already applied; finishes one cycle after ready.
  task automatic serve(input int lat, input mem_value_t result, input bit stale);
    bit         own_d;
    bit         exp_wr;
    mem_addr_t  exp_addr;
    mem_value_t exp_val;
    bit         exp_stall;
    int         n;
    own_d    = bus.d_rd | bus.d_wr;
    exp_wr   = bus.d_wr;
    exp_addr = own_d ? bus.d_addr : bus.if_addr;
    exp_val  = bus.d_wdata;
    tok_model = tok_model + 32'd1;
    bus.ctl_result = result;
    if (stale) bus.ctl_done = 1'b1;

    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.ctl_rd | bus.ctl_wr) && n < 4);
    check_val("grant_latency", 32'(n), 32'd1);

    bus.ctl_done = (lat == 1);
    for (int c = 1; c <= lat; c++) begin
      if (c > 1) begin
        @(negedge clk);
        bus.ctl_done = (c == lat);
      end
      check_val("ctl_act", bus.ctl_act, tok_model);
      check_val("ctl_addr", 32'(bus.ctl_addr), 32'(exp_addr));
      check_val("ctl_rd", 32'(bus.ctl_rd), 32'(!exp_wr));
      check_val("ctl_wr", 32'(bus.ctl_wr), 32'(exp_wr));
      if (exp_wr) check_val("ctl_value", 32'(bus.ctl_value), 32'(exp_val));
      check_val("stall_wait", 32'(bus.stall), 32'd1);
      check_val("ready_wait", 32'({bus.if_ready, bus.d_ready}), 32'd0);
    end

    @(negedge clk);
    bus.ctl_done = 1'b0;
    check_val("if_ready", 32'(bus.if_ready), 32'(!own_d));
    check_val("d_ready", 32'(bus.d_ready), 32'(own_d));
    if (!own_d) check_val("if_rdata", 32'(bus.if_rdata), 32'(result));
    else if (!exp_wr) check_val("d_rdata", 32'(bus.d_rdata), 32'(result));
    check_val("ctl_strobe_resp", 32'({bus.ctl_rd, bus.ctl_wr}), 32'd0);
    exp_stall = (bus.if_req & own_d) | ((bus.d_rd | bus.d_wr) & !own_d);
    check_val("stall_resp", 32'(bus.stall), 32'(exp_stall));
    check_val("err_main", 32'(bus.err), 32'd0);
    $display("txn %0d: %s %s addr=%04h tok=%08h lat=%0d", n_txn, own_d ? "MEM" : "IF ",
             exp_wr ? "wr" : "rd", exp_addr, tok_model, lat);
    n_txn++;
    if (own_d) begin
      bus.d_rd = 1'b0;
      bus.d_wr = 1'b0;
    end else begin
      bus.if_req = 1'b0;
    end

    @(negedge clk);
    check_val("ready_idle", 32'({bus.if_ready, bus.d_ready}), 32'd0);
    check_val("stall_idle", 32'(bus.stall), 32'(bus.if_req | bus.d_rd | bus.d_wr));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: finished got 0 expected 1");
    $fatal(1, "time limit");
  end

  initial begin
    int n;
    rst = 1'b1;
    tok_model = '0;
    drive_idle();
    @(negedge clk);
    @(negedge clk);
    check_val("rst_ctl_act", bus.ctl_act, 32'd0);
    check_val("rst_ctl_strobe", 32'({bus.ctl_rd, bus.ctl_wr}), 32'd0);
    check_val("rst_ctl_addr", 32'(bus.ctl_addr), 32'd0);
    check_val("rst_ctl_value", 32'(bus.ctl_value), 32'd0);
    check_val("rst_rdata", 32'({bus.if_rdata, bus.d_rdata}), 32'd0);
    check_val("rst_ready", 32'({bus.if_ready, bus.d_ready}), 32'd0);
    check_val("rst_err", 32'({bus.err, bus_to.err}), 32'd0);
    rst = 1'b0;

    // Single fetch.
    bus.if_req  = 1'b1;
    bus.if_addr = 16'h0004;
    serve(3, 16'h1234, 1'b0);

    // Both stages at once: the write goes first, then the held fetch.
    do_reset();
    bus.if_req  = 1'b1;
    bus.if_addr = 16'h0010;
    bus.d_wr    = 1'b1;
    bus.d_addr  = 16'h8000;
    bus.d_wdata = 16'hBEEF;
    serve(2, 16'h0000, 1'b0);
    serve(2, 16'h5678, 1'b0);

    // Slow UART write.
    bus.d_wr    = 1'b1;
    bus.d_addr  = UART_ADDR;
    bus.d_wdata = 16'h0041;
    serve(40, 16'h0000, 1'b0);

    for (int i = 0; i < 150; i++) begin
      if (!bus.if_req && ($urandom_range(1, 0) == 1)) begin
        bus.if_req  = 1'b1;
        bus.if_addr = 16'($urandom);
      end
      if (!(bus.d_rd | bus.d_wr) && ($urandom_range(2, 0) != 0)) begin
        case ($urandom_range(2, 0))
          0:       bus.d_rd = 1'b1;
          1:       bus.d_wr = 1'b1;
          default: begin
            bus.d_rd = 1'b1;
            bus.d_wr = 1'b1;
          end
        endcase
        bus.d_addr  = 16'($urandom);
        bus.d_wdata = 16'($urandom);
      end
      if (!bus.if_req && !(bus.d_rd | bus.d_wr)) begin
        bus.if_req  = 1'b1;
        bus.if_addr = 16'($urandom);
      end
      serve(int'($urandom_range(8, 1)), 16'($urandom), $urandom_range(3, 0) == 0);
    end

    // Token wrap from the all-ones token.
    dut.r_ctl_act = 32'hFFFF_FFFF;
    tok_model     = 32'hFFFF_FFFF;
    bus.d_rd   = 1'b1;
    bus.d_addr = 16'h0040;
    serve(2, 16'hA5A5, 1'b0);
    bus.if_req  = 1'b1;
    bus.if_addr = 16'h0044;
    serve(1, 16'h5A5A, 1'b0);

    // Reset while a read is waiting on the controller.
    bus.d_rd   = 1'b1;
    bus.d_addr = 16'h0222;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.ctl_rd && n < 4);
    check_val("rst_wait_grant", 32'(n), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_val("midrst_ctl_rd", 32'(bus.ctl_rd), 32'd0);
    check_val("midrst_ctl_act", bus.ctl_act, 32'd0);
    check_val("midrst_ready", 32'({bus.if_ready, bus.d_ready}), 32'd0);
    rst = 1'b0;
    tok_model = '0;
    serve(2, 16'h0BAD, 1'b0);

    // Timeout on the short-timeout instance: ready in the 17th cycle after grant.
    bus_to.d_rd   = 1'b1;
    bus_to.d_addr = 16'h0300;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) check_val("to_ctl_rd", 32'(bus_to.ctl_rd), 32'd1);
      check_val("to_d_ready", 32'(bus_to.d_ready), 32'(c == 17));
      check_val("to_err", 32'(bus_to.err), 32'(c >= 17));
      if (c == 17) begin
        check_val("to_d_rdata", 32'(bus_to.d_rdata), 32'h0000_FFFF);
        bus_to.d_rd = 1'b0;
      end
    end
    $display("txn %0d: MEM rd addr=0300 timeout", n_txn);
    n_txn++;
    bus_to.d_rd       = 1'b1;
    bus_to.ctl_result = 16'h7777;
    @(negedge clk);
    bus_to.ctl_done = 1'b1;
    @(negedge clk);
    bus_to.ctl_done = 1'b0;
    check_val("to_after_ready", 32'(bus_to.d_ready), 32'd1);
    check_val("to_after_rdata", 32'(bus_to.d_rdata), 32'h0000_7777);
    check_val("to_err_sticky", 32'(bus_to.err), 32'd1);
    bus_to.d_rd = 1'b0;
    $display("txn %0d: MEM rd addr=0300 after timeout", n_txn);
    @(negedge clk);
    check_val("main_err_final", 32'(bus.err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_access_arbiter.md
# mem_access_arbiter

Sits directly upstream of the RAM1/UART memory controller and gives it a single request port shared by the instruction-fetch (IF) stage and the data-memory (MEM) stage. The block:
- arbitrates between the two stages, data first;
- tags each accepted transaction with a fresh 32-bit action token;
- waits for the controller's token-qualified done;
- returns read data to the winning stage and produces the pipeline stall signal.

## Interface
Parameters:
- TIMEOUT, 1024: maximum cycles in WAIT before the transaction is aborted with an error.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  IF stage requests an instruction read; held until if_ready.
- if_addr  in  `MemAddr  instruction address.
- if_rdata  out  `MemValue  fetched word; valid while if_ready=1.
- if_ready  out  1  one-cycle pulse: fetch complete.
- d_rd  in  1  MEM stage read request; held until d_ready.
- d_wr  in  1  MEM stage write request; held until d_ready.
- d_addr  in  `MemAddr  data address (`UartAddr selects the UART).
- d_wdata  in  `MemValue  write data.
- d_rdata  out  `MemValue  read data; valid while d_ready=1.
- d_ready  out  1  one-cycle pulse: data access complete.
- stall  out  1  combinational: (if_req & ~if_ready) | ((d_rd|d_wr) & ~d_ready).
- ctl_rd, ctl_wr  out  1  to controller mem_rd / mem_wr.
- ctl_addr  out  `MemAddr  to controller mem_addr.
- ctl_value  out  `MemValue  to controller mem_value.
- ctl_act  out  32  action token to controller mem_act.
- ctl_done  in  1  controller uart_work_done (already token-qualified).
- ctl_result  in  `MemValue  controller result.
- err  out  1  sticky timeout flag.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE:
  - If d_rd|d_wr: grant data. If both d_rd and d_wr are set, treat it as a write.
  - Else if if_req: grant fetch.
  - On grant: latch op, addr, wdata and the owner; ctl_act <= ctl_act+1; clear the timeout counter; go to WAIT.
- WAIT:
  - Drive the latched request on ctl_*.
  - When ctl_done=1: latch ctl_result into the owner's rdata register and go to RESP. Latch on writes too; the value is then don't-care.
  - When the counter reaches TIMEOUT-1 without done: set err, load rdata with 16'hFFFF, go to RESP.
- RESP:
  - Pulse the owner's ready for exactly one cycle.
  - Deassert ctl_rd/ctl_wr.
  - Return to IDLE.
- Requests are level-held by the stages. The request seen in IDLE right after RESP is treated as a new transaction.
- Strict data priority is intentional: the MEM instruction is older, and the pipeline advances on d_ready, so fetch cannot starve.
- Token arithmetic: 32-bit wrap-around; 32'hFFFFFFFF+1 = 0 is legal. The controller only compares tokens for inequality.
- ctl_rd/ctl_wr are 0 in IDLE and RESP. ctl_addr, ctl_value and ctl_act hold stable for the whole of WAIT.

## Timing
- Reset values:
  - state=IDLE, ctl_act=0, ctl_rd=ctl_wr=0;
  - ctl_addr=ctl_value=0;
  - if_rdata=d_rdata=0, if_ready=d_ready=0, err=0.
  - The first token issued after reset is 1.
- Reset mid-transaction: everything returns to reset values on the next edge. No ready pulse is produced, and the held request is re-arbitrated afterwards.
- Latency (request seen in IDLE at edge N, ctl_done first high in WAIT):
  - ctl_* valid from N+1;
  - done sampled at edge N+k (k≥1); ready=1 in cycle N+k through N+k+1.
  - Minimum request-to-ready: 2 cycles. Back-to-back throughput: one transaction per k+2 cycles.
- A stale ctl_done=1 from the previous token is impossible, because the controller compares against the new ctl_act combinationally. The block still ignores ctl_done in the grant cycle itself.
- Both stages requesting in the same IDLE cycle: data in WAIT, fetch waits; stall stays high for both.

## Structure
- Shared definitions file: `MemAddr, `MemValue, `UartAddr, plus a new `ActToken (31:0) and the state encodings ARB_IDLE/ARB_WAIT/ARB_RESP.
- No sub-module. The timeout counter is inline (width clog2(TIMEOUT)).

## Test plan
- Single fetch: if_req, if_addr=16'h0004; controller model returns 16'h1234 with done 3 cycles after the token change. Required: ctl_act=1, if_rdata=16'h1234, one-cycle if_ready, stall high until then.
- Simultaneous requests: if_req plus d_wr to 16'h8000 with data 16'hBEEF. Required: write issued first (ctl_wr=1, ctl_act=1); fetch issued next with ctl_act=2.
- UART write: d_wr to `UartAddr, data 16'h0041; controller done after 40 cycles. Required: ctl_* stable throughout WAIT, d_ready exactly once, err=0.
- Timeout: ctl_done held 0 with TIMEOUT=16. Required: d_ready at the 17th cycle after grant, d_rdata=16'hFFFF, err=1 and it stays 1.
- Token wrap: preload ctl_act to 32'hFFFFFFFF via 2^32-1 forced state. Required: the next grant drives 0 and completes normally.
- Reset mid-WAIT: rst during a read. Required: ctl_rd=0, ctl_act=0, no ready pulse; after release the held request reissues with ctl_act=1.
